// File: rtl/regfile_wr_decoder.sv
// Registered SEL_W-to-2^SEL_W write-enable decoder with valid/ready handshake,
// hardwired-zero-register masking and a clear sweep after reset or on request.
module regfile_wr_decoder #(
    parameter int SEL_W        = 5,
    parameter bit ZERO_REG_EN  = 1'b1,
    parameter int ZERO_REG_IDX = 31
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_valid,
    input  logic [SEL_W-1:0]        wr_sel,
    output logic                    wr_ready,
    input  logic                    clear_req,
    output logic [(1<<SEL_W)-1:0]   wr_en_out,
    output logic                    clear_active,
    output logic                    clear_done,
    output logic                    zero_drop,
    output logic                    busy
);

    localparam int N = 1 << SEL_W;
    // One extra index bit marks the completion edge after onehot(N-1) is loaded.
    localparam logic [SEL_W:0]   SWEEP_END = {1'b1, {SEL_W{1'b0}}};
    localparam logic [SEL_W:0]   IDX_ONE   = {{SEL_W{1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0] ZERO_SEL  = SEL_W'(ZERO_REG_IDX);

    typedef enum logic {SWEEP, RUN} state_t;

    state_t           state_q, state_d;
    logic [SEL_W:0]   sweep_idx_q, sweep_idx_d;
    logic [N-1:0]     wr_en_q, wr_en_d;
    logic             clear_active_q, clear_active_d;
    logic             clear_done_q, clear_done_d;
    logic             zero_drop_q, zero_drop_d;
    logic             busy_q, busy_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; that is what keeps this block from inferring latches.
        state_d        = state_q;
        sweep_idx_d    = sweep_idx_q;
        wr_en_d        = '0;
        clear_active_d = 1'b0;
        clear_done_d   = 1'b0;
        zero_drop_d    = 1'b0;
        busy_d         = busy_q;
        wr_ready       = 1'b0;

        unique case (state_q)
            SWEEP: begin
                if (sweep_idx_q == SWEEP_END) begin
                    state_d      = RUN;
                    sweep_idx_d  = '0;
                    clear_done_d = 1'b1;
                    busy_d       = 1'b0;
                end else begin
                    wr_en_d[sweep_idx_q[SEL_W-1:0]] = 1'b1;
                    clear_active_d = 1'b1;
                    sweep_idx_d    = sweep_idx_q + IDX_ONE;
                end
            end
            RUN: begin
                wr_ready = !clear_req;
                if (clear_req) begin
                    state_d     = SWEEP;
                    sweep_idx_d = '0;
                    busy_d      = 1'b1;
                end else if (wr_valid) begin
                    // wr_sel is only looked at once the write is accepted.
                    if (ZERO_REG_EN && (wr_sel == ZERO_SEL)) begin
                        zero_drop_d = 1'b1;
                    end else begin
                        wr_en_d[wr_sel] = 1'b1;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= SWEEP;
            sweep_idx_q    <= '0;
            wr_en_q        <= '0;
            clear_active_q <= 1'b0;
            clear_done_q   <= 1'b0;
            zero_drop_q    <= 1'b0;
            busy_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            sweep_idx_q    <= sweep_idx_d;
            wr_en_q        <= wr_en_d;
            clear_active_q <= clear_active_d;
            clear_done_q   <= clear_done_d;
            zero_drop_q    <= zero_drop_d;
            busy_q         <= busy_d;
        end
    end

    assign wr_en_out    = wr_en_q;
    assign clear_active = clear_active_q;
    assign clear_done   = clear_done_q;
    assign zero_drop    = zero_drop_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_regfile_wr_decoder.sv
// Scoreboard bench for regfile_wr_decoder: three instances (32-way masked,
// 32-way unmasked, 8-way masked at 7) share one stimulus stream.
module tb_regfile_wr_decoder;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [31:0] wr_en;
        logic        ca;
        logic        cd;
        logic        zd;
        logic        busy;
        logic        run;
    } exp_t;

    typedef struct {
        bit run;
        int pulses;
    } mstate_t;

    localparam exp_t RST_EXP = '{wr_en: 32'd0, ca: 1'b0, cd: 1'b0, zd: 1'b0, busy: 1'b1, run: 1'b0};

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        wr_valid  = 1'b0;
    logic        clear_req = 1'b0;
    logic [4:0]  wr_sel    = 5'd0;

    logic [31:0] en5, en5n;
    logic [7:0]  en3;
    logic [2:0]  rdy, ca, cd, zd, bsy;
    logic [31:0] act_en [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    exp_t    exp_q [NDUT][$];
    mstate_t ms    [NDUT];
    int      n_a    [NDUT] = '{32, 32, 8};
    bit      zen_a  [NDUT] = '{1'b1, 1'b0, 1'b1};
    int      zidx_a [NDUT] = '{31, 31, 7};

    always #5 clk = ~clk;

    regfile_wr_decoder #(.SEL_W(5), .ZERO_REG_EN(1'b1), .ZERO_REG_IDX(31)) dut5 (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_sel(wr_sel),
        .wr_ready(rdy[0]), .clear_req(clear_req), .wr_en_out(en5),
        .clear_active(ca[0]), .clear_done(cd[0]), .zero_drop(zd[0]), .busy(bsy[0])
    );

    regfile_wr_decoder #(.SEL_W(5), .ZERO_REG_EN(1'b0), .ZERO_REG_IDX(31)) dut5n (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_sel(wr_sel),
        .wr_ready(rdy[1]), .clear_req(clear_req), .wr_en_out(en5n),
        .clear_active(ca[1]), .clear_done(cd[1]), .zero_drop(zd[1]), .busy(bsy[1])
    );

    regfile_wr_decoder #(.SEL_W(3), .ZERO_REG_EN(1'b1), .ZERO_REG_IDX(7)) dut3 (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_sel(wr_sel[2:0]),
        .wr_ready(rdy[2]), .clear_req(clear_req), .wr_en_out(en3),
        .clear_active(ca[2]), .clear_done(cd[2]), .zero_drop(zd[2]), .busy(bsy[2])
    );

    assign act_en[0] = en5;
    assign act_en[1] = en5n;
    assign act_en[2] = {24'd0, en3};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a sweep emits pulses 0..n-1 then one completion edge; RUN
    // turns each accepted write into one pulse unless it targets the zero register.
    function automatic exp_t model_step(inout mstate_t s, input int n, input bit zen,
                                        input int zidx, input bit v, input bit c, input int sel);
        exp_t e;
        e = '0;
        if (!s.run) begin
            if (s.pulses < n) begin
                e.wr_en = 32'd1 << s.pulses;
                e.ca    = 1'b1;
                e.busy  = 1'b1;
                s.pulses++;
            end else begin
                e.cd     = 1'b1;
                s.run    = 1'b1;
                s.pulses = 0;
            end
        end else if (c) begin
            s.run    = 1'b0;
            s.pulses = 0;
            e.busy   = 1'b1;
        end else if (v) begin
            if (zen && sel == zidx) e.zd = 1'b1;
            else                    e.wr_en = 32'd1 << sel;
        end
        e.run = s.run;
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            for (int i = 0; i < NDUT; i++) begin
                if (!reset_n) begin
                    ms[i].run    = 1'b0;
                    ms[i].pulses = 0;
                    exp_q[i].delete();
                    exp_q[i].push_back(RST_EXP);
                end else begin
                    exp_q[i].push_back(model_step(ms[i], n_a[i], zen_a[i], zidx_a[i],
                                                  wr_valid, clear_req, int'(wr_sel) % n_a[i]));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("dut%0d expectation queue", i), 64'd0, 64'd1);
                end else begin
                    e = exp_q[i].pop_front();
                    check($sformatf("dut%0d outputs", i),
                          {act_en[i], ca[i], cd[i], zd[i], bsy[i], rdy[i]},
                          {e.wr_en, e.ca, e.cd, e.zd, e.busy, e.run && !clear_req});
                end
                check($sformatf("dut%0d onehot", i),
                      ($countones(act_en[i]) <= 1) ? 64'd1 : 64'd0, 64'd1);
            end
        end
    end

    task automatic drive(input bit v, input int sel, input bit c);
        @(posedge clk);
        #1;
        wr_valid  = v;
        wr_sel    = 5'(sel);
        clear_req = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(40);

        drive(1'b1, 3, 1'b0);
        drive(1'b1, 7, 1'b0);
        drive(1'b1, 30, 1'b0);
        drive(1'b0, 0, 1'b0);
        drive(1'b1, 31, 1'b0);
        drive(1'b0, 0, 1'b0);
        for (int s = 0; s < 8; s++) drive(1'b1, s, 1'b0);
        drive(1'b0, 0, 1'b0);

        drive(1'b1, 5, 1'b1);
        drive(1'b0, 0, 1'b0);
        idle(10);
        drive(1'b1, 9, 1'b1);
        idle(40);

        for (int k = 0; k < 300; k++) begin
            drive(($urandom % 10) < 7, int'($urandom % 32), ($urandom % 40) == 0);
        end
        idle(2);

        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (13) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("dut5 async reset", {en5, ca[0], cd[0], zd[0], bsy[0]}, {32'd0, 4'b0001});
        check("dut5n async reset", {en5n, ca[1], cd[1], zd[1], bsy[1]}, {32'd0, 4'b0001});
        check("dut3 async reset", {24'd0, en3, ca[2], cd[2], zd[2], bsy[2]}, {32'd0, 4'b0001});
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
